// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: round-robin arbiter sharing a bank of JK flops, one 4-cycle transaction per grant.
// Optional self-check output chk_fail enabled by defining JK_BANK_CTRL_CHECK_EN.
module jk_bank_ctrl #(
  parameter int N_REQ  = 4,
  parameter int NUM_FF = 8,
  parameter int IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [IDX_W*N_REQ-1:0] idx,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic                   rdata,
  output logic                   err,
  output logic [NUM_FF-1:0]      j,
  output logic [NUM_FF-1:0]      k,
  input  logic [NUM_FF-1:0]      q
`ifdef JK_BANK_CTRL_CHECK_EN
  ,
  output logic                   chk_fail
`endif
);
  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [RW-1:0] rr, rr_n, win, win_n, pick;
  logic found;
  logic [1:0] op_w;
  logic [IDX_W-1:0] idx_w, idx_l, idx_l_n;
  logic [NUM_FF-1:0] sel_w, sel_l, j_n, k_n;
  logic [N_REQ-1:0] gnt_n;
  logic done_n, rdata_n, err_n;
`ifdef JK_BANK_CTRL_CHECK_EN
  logic [1:0] op_l, op_l_n;
  logic pre, pre_n, chk_n, expect_q;
`endif
  // Scan downward so the last hit is the lowest index at or after rr.
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr) + i) % N_REQ]) begin
        pick = RW'((int'(rr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end
  assign op_w  = op[2*int'(pick) +: 2];
  assign idx_w = idx[IDX_W*int'(pick) +: IDX_W];
  assign sel_w = NUM_FF'(1) << idx_w;
  assign sel_l = NUM_FF'(1) << idx_l;
  always_comb begin
    state_n = state;
    rr_n = rr;
    win_n = win;
    idx_l_n = idx_l;
    gnt_n = gnt;
    done_n = done;
    rdata_n = rdata;
    err_n = err;
    j_n = '0;
    k_n = '0;
`ifdef JK_BANK_CTRL_CHECK_EN
    op_l_n = op_l;
    pre_n = pre;
    chk_n = chk_fail;
    expect_q = (op_l == 2'b00) ? pre : (op_l == 2'b01) ? 1'b0 : (op_l == 2'b10) ? 1'b1 : ~pre;
`endif
    case (state)
      IDLE: if (found) begin
        state_n = DRIVE;
        win_n = pick;
        idx_l_n = idx_w;
        gnt_n = N_REQ'(1) << pick;
        j_n = op_w[1] ? sel_w : '0;
        k_n = op_w[0] ? sel_w : '0;
`ifdef JK_BANK_CTRL_CHECK_EN
        op_l_n = op_w;
        pre_n = |(q & sel_w);
`endif
      end
      DRIVE: state_n = SAMPLE;
      SAMPLE: begin
        state_n = DONE;
        done_n = 1'b1;
        err_n = 32'(idx_l) >= NUM_FF;
        rdata_n = |(q & sel_l);
`ifdef JK_BANK_CTRL_CHECK_EN
        chk_n = !err_n && (rdata_n != expect_q);
`endif
      end
      default: begin
        state_n = IDLE;
        done_n = 1'b0;
        rdata_n = 1'b0;
        err_n = 1'b0;
        gnt_n = '0;
        rr_n = (win == RW'(N_REQ - 1)) ? '0 : win + 1'b1;
`ifdef JK_BANK_CTRL_CHECK_EN
        chk_n = 1'b0;
`endif
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      win <= '0;
      idx_l <= '0;
      gnt <= '0;
      done <= 1'b0;
      rdata <= 1'b0;
      err <= 1'b0;
      j <= '0;
      k <= '0;
`ifdef JK_BANK_CTRL_CHECK_EN
      op_l <= '0;
      pre <= 1'b0;
      chk_fail <= 1'b0;
`endif
    end else begin
      state <= state_n;
      rr <= rr_n;
      win <= win_n;
      idx_l <= idx_l_n;
      gnt <= gnt_n;
      done <= done_n;
      rdata <= rdata_n;
      err <= err_n;
      j <= j_n;
      k <= k_n;
`ifdef JK_BANK_CTRL_CHECK_EN
      op_l <= op_l_n;
      pre <= pre_n;
      chk_fail <= chk_n;
`endif
    end
  end
endmodule
